// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 device-side responder.
// Config word layout is {S/D, O/S, S1, S0, UNI, SLP}, shifted in MSB first on SDI.
package ltc2308_pkg;

   localparam int RES_W = 12;
   localparam int CFG_W = 6;

   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;
   localparam logic [RES_W-1:0] SIGN_FLIP = {1'b1, {(RES_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_XFER
   } state_t;

   // Odd/sign selects the odd channel of a pair, so it lands in the index LSB.
   function automatic logic [2:0] ch_decode(input logic [CFG_W-1:0] c);
      return {c[CFG_S1], c[CFG_S0], c[CFG_OS]};
   endfunction

endpackage

// File: rtl/ltc2308_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus pin, with rise/fall pulses
// derived from the synchronized level against its registered previous value.
module ltc2308_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/ltc2308_responder.sv
// Device-side LTC2308 model: serves 12-bit channel samples over CONVST/SCK/SDI/SDO.
// Define LTC2308_RESP_ERR_EN to build the protocol-violation counter on err_cnt.
module ltc2308_responder
   import ltc2308_pkg::*;
#(
   parameter int CONV_CYCLES = 80,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 adc_convst,
   input  logic                 adc_sck,
   input  logic                 adc_sdi,
   output logic                 adc_sdo,
   input  logic [8*RES_W-1:0]   ch_data,
   output logic [CFG_W-1:0]     cfg,
   output logic                 cfg_valid,
   output logic                 sample_strobe,
   output logic [7:0]           err_cnt
);

   localparam int          CNT_W     = $clog2(CONV_CYCLES + 1);
   localparam logic [3:0]  CFG_BITS  = 4'(CFG_W);
   localparam logic [3:0]  LAST_BIT  = 4'(RES_W - 1);

   logic convst_rise, sck_rise, sck_fall, sdi_level;
   logic convst_level_unused, convst_fall_unused, sck_level_unused;
   logic sdi_rise_unused, sdi_fall_unused;

   state_t             state, next_state;
   logic [CNT_W-1:0]   conv_cnt;
   logic [3:0]         bit_cnt;
   logic [RES_W-1:0]   hold, shift;
   logic [CFG_W-1:0]   cfg_sr;
   logic [2:0]         cur_ch;

   logic start_conv, conv_done, take_rise, take_fall, xfer_done;

   ltc2308_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_convst (
      .clk(clk), .reset(reset), .din(adc_convst),
      .level(convst_level_unused), .rise(convst_rise), .fall(convst_fall_unused)
   );

   ltc2308_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .reset(reset), .din(adc_sck),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );

   ltc2308_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(clk), .reset(reset), .din(adc_sdi),
      .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // A CONVST rise in XFER takes priority over any SCK edge in the same cycle.
   always_comb begin
      next_state = state;
      start_conv = 1'b0;
      conv_done  = 1'b0;
      take_rise  = 1'b0;
      take_fall  = 1'b0;
      xfer_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (convst_rise) begin
               start_conv = 1'b1;
               next_state = ST_CONV;
            end
         end
         ST_CONV: begin
            if (conv_cnt == CNT_W'(CONV_CYCLES - 1)) begin
               conv_done  = 1'b1;
               next_state = ST_XFER;
            end
         end
         ST_XFER: begin
            if (convst_rise) begin
               start_conv = 1'b1;
               next_state = ST_CONV;
            end else begin
               take_rise = sck_rise;
               take_fall = sck_fall;
               if (sck_rise && bit_cnt == LAST_BIT) begin
                  xfer_done  = 1'b1;
                  next_state = ST_IDLE;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         conv_cnt      <= '0;
         bit_cnt       <= '0;
         hold          <= '0;
         shift         <= '0;
         cfg_sr        <= '0;
         cfg           <= CFG_RESET;
         cur_ch        <= '0;
         cfg_valid     <= 1'b0;
         sample_strobe <= 1'b0;
         adc_sdo       <= 1'b0;
      end else begin
         cfg_valid     <= 1'b0;
         sample_strobe <= 1'b0;
         adc_sdo       <= (state == ST_XFER) ? shift[RES_W-1] : 1'b0;

         if (start_conv) begin
            hold          <= ch_data[int'(cur_ch)*RES_W +: RES_W];
            sample_strobe <= 1'b1;
            conv_cnt      <= '0;
         end else if (state == ST_CONV) begin
            conv_cnt <= conv_cnt + CNT_W'(1);
         end

         // Bipolar results are offset binary flipped into two's complement.
         if (conv_done) begin
            shift   <= cfg[CFG_UNI] ? hold : (hold ^ SIGN_FLIP);
            bit_cnt <= '0;
         end

         if (take_rise) begin
            if (bit_cnt < CFG_BITS) cfg_sr <= {cfg_sr[CFG_W-2:0], sdi_level};
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (take_fall) shift <= {shift[RES_W-2:0], 1'b0};

         if (xfer_done) begin
            cfg       <= cfg_sr;
            cfg_valid <= 1'b1;
            cur_ch    <= ch_decode(cfg_sr);
         end
      end
   end

`ifdef LTC2308_RESP_ERR_EN
   logic violation;

   always_comb violation = (state == ST_CONV) && (convst_rise || sck_rise || sck_fall);

   always_ff @(posedge clk) begin
      if (!reset)                               err_cnt <= '0;
      else if (violation && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ltc2308_responder.sv
// Scoreboard bench for ltc2308_responder: a host driver issues conversions and
// transfers while monitors pop expected words, configs and strobes.
module tb_ltc2308_responder;
   import ltc2308_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              adc_convst, adc_sck, adc_sdi;
   logic              adc_sdo;
   logic [8*RES_W-1:0] ch_data;
   logic [CFG_W-1:0]  cfg;
   logic              cfg_valid, sample_strobe;
   logic [7:0]        err_cnt;

   logic [11:0] chv [8];
   logic [11:0] rx_word;
   logic        rx_valid;

   logic [11:0] word_q[$];
   logic [5:0]  cfg_q[$];
   int          strobe_q[$];

   int vectors = 0;
   int miscompares = 0;

`ifdef LTC2308_RESP_ERR_EN
   localparam logic [7:0] EXP_ERR = 8'd1;
`else
   localparam logic [7:0] EXP_ERR = 8'd0;
`endif

   ltc2308_responder #(.CONV_CYCLES(80), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
      .adc_sdo(adc_sdo), .ch_data(ch_data),
      .cfg(cfg), .cfg_valid(cfg_valid), .sample_strobe(sample_strobe),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 8; k++) ch_data[12*k +: 12] = chv[k];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // DUT pulse outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (sample_strobe) begin
         checkOutput("strobe_expected", 32'(strobe_q.size() != 0), 32'd1);
         if (strobe_q.size() != 0) void'(strobe_q.pop_front());
      end
      if (cfg_valid) begin
         checkOutput("cfg_valid_expected", 32'(cfg_q.size() != 0), 32'd1);
         if (cfg_q.size() != 0) checkOutput("cfg", 32'(cfg), 32'(cfg_q.pop_front()));
      end
   end

   always @(posedge clk) begin
      if (rx_valid) begin
         checkOutput("word_expected", 32'(word_q.size() != 0), 32'd1);
         if (word_q.size() != 0) checkOutput("sdo_word", 32'(rx_word), 32'(word_q.pop_front()));
      end
   end

   // Raises CONVST, optionally a second time mid-conversion, and times the strobe and SDO MSB.
   task automatic applyStimulus(input int second_at, input bit measure_sdo);
      int strobe_at = -1;
      int sdo_at = -1;
      strobe_q.push_back(1);
      @(negedge clk) adc_convst = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 4) adc_convst = 1'b0;
         if (second_at != 0 && k == second_at) adc_convst = 1'b1;
         if (second_at != 0 && k == second_at + 4) adc_convst = 1'b0;
         if (sample_strobe && strobe_at < 0) strobe_at = k;
         if (adc_sdo && sdo_at < 0) sdo_at = k;
      end
      checkOutput("strobe_latency", 32'(strobe_at), 32'd3);
      if (measure_sdo) checkOutput("xfer_latency", 32'(sdo_at), 32'd84);
   endtask

   // Host SPI: SCK half-period of 6 clk cycles, SDO sampled just before each SCK rise.
   task automatic spiXfer(input logic [5:0] sdi_w, input int nsck, input bit report, output logic [11:0] rx);
      rx = '0;
      for (int i = 0; i < nsck; i++) begin
         adc_sdi = (i < 6) ? sdi_w[5-i] : 1'b0;
         repeat (6) @(negedge clk);
         rx = {rx[10:0], adc_sdo};
         adc_sck = 1'b1;
         repeat (6) @(negedge clk);
         adc_sck = 1'b0;
      end
      adc_sdi = 1'b0;
      repeat (6) @(negedge clk);
      if (report) begin
         rx_word  = rx;
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic fullXfer(input logic [5:0] sdi_w, input logic [11:0] exp_word);
      logic [11:0] rx;
      word_q.push_back(exp_word);
      cfg_q.push_back(sdi_w);
      spiXfer(sdi_w, 12, 1'b1, rx);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [11:0] rx;
      reset = 1'b0;
      adc_convst = 1'b0;
      adc_sck = 1'b0;
      adc_sdi = 1'b0;
      rx_valid = 1'b0;
      rx_word = '0;
      chv[0] = 12'hA5C; chv[1] = 12'h3C7; chv[2] = 12'h9E1; chv[3] = 12'h123;
      chv[4] = 12'h456; chv[5] = 12'h789; chv[6] = 12'hABC; chv[7] = 12'hDEF;

      repeat (4) @(negedge clk);
      checkOutput("rst_sdo", 32'(adc_sdo), 32'd0);
      checkOutput("rst_cfg", 32'(cfg), 32'h22);
      checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
      checkOutput("rst_strobe", 32'(sample_strobe), 32'd0);
      checkOutput("rst_err", 32'(err_cnt), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] ch0 unipolar read, then select single-ended ch1");
      applyStimulus(0, 1'b1);
      fullXfer(6'b110010, 12'hA5C);

      $display("[TB] ch1 read, then select bipolar ch0");
      applyStimulus(0, 1'b0);
      fullXfer(6'b100000, 12'h3C7);

      $display("[TB] bipolar extremes on ch0");
      chv[0] = 12'h000;
      applyStimulus(0, 1'b1);
      fullXfer(6'b100000, 12'h800);
      chv[0] = 12'hFFF;
      applyStimulus(0, 1'b0);
      fullXfer(6'b100010, 12'h7FF);

      $display("[TB] second CONVST during conversion");
      chv[0] = 12'hA5C;
      applyStimulus(20, 1'b1);
      checkOutput("err_after_double", 32'(err_cnt), 32'(EXP_ERR));
      fullXfer(6'b110010, 12'hA5C);

      $display("[TB] CONVST aborts a partial transfer");
      applyStimulus(0, 1'b0);
      spiXfer(6'b000111, 5, 1'b0, rx);
      applyStimulus(0, 1'b0);
      checkOutput("abort_cfg_kept", 32'(cfg), 32'h32);
      fullXfer(6'b100110, 12'h3C7);
      checkOutput("err_after_abort", 32'(err_cnt), 32'(EXP_ERR));

      $display("[TB] reset in the middle of a transfer");
      applyStimulus(0, 1'b1);
      spiXfer(6'b000000, 3, 1'b0, rx);
      checkOutput("pre_reset_sdo", 32'(adc_sdo), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_sdo", 32'(adc_sdo), 32'd0);
      checkOutput("mid_rst_cfg", 32'(cfg), 32'h22);
      checkOutput("mid_rst_err", 32'(err_cnt), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      spiXfer(6'b111111, 12, 1'b0, rx);
      checkOutput("idle_sdo_word", 32'(rx), 32'd0);
      checkOutput("idle_cfg", 32'(cfg), 32'h22);

      $display("[TB] channel reset to ch0 after reset");
      applyStimulus(0, 1'b1);
      fullXfer(6'b100010, 12'hA5C);

      repeat (10) @(negedge clk);
      checkOutput("word_q_drained", 32'(word_q.size()), 32'd0);
      checkOutput("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
      checkOutput("strobe_q_drained", 32'(strobe_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
